// File: rtl/md_unit_if.sv
// Issue/result bundle between control+GRF and the multiply/divide unit.
// The master drives the issue side; the slave returns busy and the HI/LO registers.
interface md_unit_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, md_op, src_a, src_b, input busy, hi, lo);
  modport slave  (input start, md_op, src_a, src_b, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle MIPS multiply/divide unit holding the architectural HI/LO registers.
// Operands are latched at issue; the result is written when the fixed busy window expires.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  md_unit_if.slave   bus
);

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } md_op_t;

  typedef enum logic {IDLE, BUSY} state_t;

  localparam int unsigned CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  state_t      state;
  md_op_t      op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [CW-1:0] count;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] div_u;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        res_we;

  // Signed divide works on magnitudes and fixes signs afterwards; this also
  // yields 0x80000000 / -1 = 0x80000000 rem 0 without a special case.
  always_comb begin
    prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u = {32'd0, a_q} * {32'd0, b_q};
    mag_a  = a_q[31] ? (32'd0 - a_q) : a_q;
    mag_b  = b_q[31] ? (32'd0 - b_q) : b_q;
    if (mag_b == '0) mag_b = 32'd1;
    q_s    = mag_a / mag_b;
    r_s    = mag_a % mag_b;
    if (a_q[31] != b_q[31]) q_s = 32'd0 - q_s;
    if (a_q[31]) r_s = 32'd0 - r_s;
    div_u  = (b_q == '0) ? 32'd1 : b_q;
    q_u    = a_q / div_u;
    r_u    = a_q % div_u;

    res_hi = '0;
    res_lo = '0;
    res_we = 1'b0;
    case (op_q)
      OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; res_we = 1'b1; end
      OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; res_we = 1'b1; end
      OP_DIV:   begin res_hi = r_s; res_lo = q_s; res_we = (b_q != '0); end
      OP_DIVU:  begin res_hi = r_u; res_lo = q_u; res_we = (b_q != '0); end
      default:  ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= OP_MULT;
      a_q      <= '0;
      b_q      <= '0;
      count    <= '0;
      bus.busy <= 1'b0;
      bus.hi   <= '0;
      bus.lo   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            case (bus.md_op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                op_q     <= md_op_t'(bus.md_op);
                a_q      <= bus.src_a;
                b_q      <= bus.src_b;
                count    <= bus.md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                bus.busy <= 1'b1;
                state    <= BUSY;
              end
              OP_MTHI: bus.hi <= bus.src_a;
              OP_MTLO: bus.lo <= bus.src_a;
              default: ;
            endcase
          end
        end
        BUSY: begin
          if (count == CW'(1)) begin
            count    <= '0;
            bus.busy <= 1'b0;
            state    <= IDLE;
            if (res_we) begin
              bus.hi <= res_hi;
              bus.lo <= res_lo;
            end
          end else begin
            count <= count - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios plus randomized ops
// compared against a 64-bit arithmetic model of HI/LO and busy duration.
module tb_md_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_unit_if bus();
  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int fails  = 0;
  logic [31:0] m_hi, m_lo;

  // Reference: architectural effect of one accepted op and its busy length.
  function automatic void model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                   inout logic [31:0] h, inout logic [31:0] l, output int cyc);
    longint sa, sb, q, r;
    longint unsigned ua, ub, p;
    logic [63:0] prod;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    cyc = 0;
    case (op)
      3'd0: begin prod = sa * sb; h = prod[63:32]; l = prod[31:0]; cyc = 5; end
      3'd1: begin p = ua * ub; prod = p; h = prod[63:32]; l = prod[31:0]; cyc = 5; end
      3'd2: begin
        cyc = 10;
        if (b != 0) begin q = sa / sb; r = sa % sb; l = q[31:0]; h = r[31:0]; end
      end
      3'd3: begin
        cyc = 10;
        if (b != 0) begin l = a / b; h = a % b; end
      end
      3'd4: h = a;
      3'd5: l = a;
      default: ;
    endcase
  endfunction

  // Issue one op, scramble the operand inputs after the issue edge, and count
  // busy cycles; returns to the caller in the first cycle busy reads 0.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int n, output bit stable);
    logic [31:0] h0, l0;
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = op; bus.src_a = a; bus.src_b = b;
    h0 = bus.hi; l0 = bus.lo;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.src_a = $urandom; bus.src_b = $urandom;
    n = 0; stable = 1'b1;
    while (bus.busy === 1'b1 && n < 100) begin
      if (bus.hi !== h0 || bus.lo !== l0) stable = 1'b0;
      n++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; bus.start = 1'b0; bus.md_op = '0; bus.src_a = '0; bus.src_b = '0;
    repeat (2) @(posedge clk);
    #1;
    m_hi = '0; m_lo = '0;
    @(negedge clk); reset = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.hi !== 32'd0) begin fails++; $display("FAIL reset_hi: got %h expected 00000000", bus.hi); end
    checks++; if (bus.lo !== 32'd0) begin fails++; $display("FAIL reset_lo: got %h expected 00000000", bus.lo); end
  endtask

  task automatic test_mult();
    int n, c; bit st;
    run_op(3'd0, 32'hFFFFFFFF, 32'h2, n, st);
    model_op(3'd0, 32'hFFFFFFFF, 32'h2, m_hi, m_lo, c);
    checks++; if (n !== 5) begin fails++; $display("FAIL mult_busy_len: got %0d expected 5", n); end
    checks++; if (!st) begin fails++; $display("FAIL mult_hold: hi/lo changed during busy, expected held at 0"); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL mult_hi: got %h expected ffffffff", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFFFFFE) begin fails++; $display("FAIL mult_lo: got %h expected fffffffe", bus.lo); end
    run_op(3'd1, 32'hFFFFFFFF, 32'h2, n, st);
    model_op(3'd1, 32'hFFFFFFFF, 32'h2, m_hi, m_lo, c);
    checks++; if (n !== 5) begin fails++; $display("FAIL multu_busy_len: got %0d expected 5", n); end
    checks++; if (bus.hi !== 32'h1) begin fails++; $display("FAIL multu_hi: got %h expected 00000001", bus.hi); end
    checks++; if (bus.lo !== 32'hFFFFFFFE) begin fails++; $display("FAIL multu_lo: got %h expected fffffffe", bus.lo); end
  endtask

  task automatic test_div();
    int n, c; bit st;
    run_op(3'd2, 32'hFFFFFFF9, 32'h2, n, st);
    model_op(3'd2, 32'hFFFFFFF9, 32'h2, m_hi, m_lo, c);
    checks++; if (n !== 10) begin fails++; $display("FAIL div_busy_len: got %0d expected 10", n); end
    checks++; if (bus.lo !== 32'hFFFFFFFD) begin fails++; $display("FAIL div_lo: got %h expected fffffffd", bus.lo); end
    checks++; if (bus.hi !== 32'hFFFFFFFF) begin fails++; $display("FAIL div_hi: got %h expected ffffffff", bus.hi); end
    run_op(3'd3, 32'd7, 32'd2, n, st);
    model_op(3'd3, 32'd7, 32'd2, m_hi, m_lo, c);
    checks++; if (bus.lo !== 32'd3 || bus.hi !== 32'd1) begin fails++; $display("FAIL divu_result: got hi=%h lo=%h expected hi=00000001 lo=00000003", bus.hi, bus.lo); end
    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF, n, st);
    model_op(3'd2, 32'h80000000, 32'hFFFFFFFF, m_hi, m_lo, c);
    checks++; if (bus.lo !== 32'h80000000 || bus.hi !== 32'd0) begin fails++; $display("FAIL div_overflow: got hi=%h lo=%h expected hi=00000000 lo=80000000", bus.hi, bus.lo); end
  endtask

  task automatic test_mthi_mtlo_divzero();
    int n, c; bit st;
    run_op(3'd4, 32'h1234, 32'h0, n, st);
    model_op(3'd4, 32'h1234, 32'h0, m_hi, m_lo, c);
    checks++; if (n !== 0) begin fails++; $display("FAIL mthi_busy: got %0d busy cycles expected 0", n); end
    checks++; if (bus.hi !== 32'h1234) begin fails++; $display("FAIL mthi_hi: got %h expected 00001234", bus.hi); end
    run_op(3'd5, 32'h5678, 32'h0, n, st);
    model_op(3'd5, 32'h5678, 32'h0, m_hi, m_lo, c);
    checks++; if (bus.lo !== 32'h5678) begin fails++; $display("FAIL mtlo_lo: got %h expected 00005678", bus.lo); end
    run_op(3'd2, 32'h99, 32'h0, n, st);
    model_op(3'd2, 32'h99, 32'h0, m_hi, m_lo, c);
    checks++; if (n !== 10) begin fails++; $display("FAIL divzero_busy_len: got %0d expected 10", n); end
    checks++; if (bus.hi !== 32'h1234 || bus.lo !== 32'h5678) begin fails++; $display("FAIL divzero_keep: got hi=%h lo=%h expected hi=00001234 lo=00005678", bus.hi, bus.lo); end
  endtask

  task automatic test_isolation();
    int n, c; bit st;
    logic [31:0] h0, l0;
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = 3'd0; bus.src_a = 32'd3; bus.src_b = 32'd4;
    h0 = bus.hi; l0 = bus.lo;
    @(posedge clk); #1;
    bus.start = 1'b0; n = 0; st = 1'b1;
    while (bus.busy === 1'b1 && n < 100) begin
      if (bus.hi !== h0 || bus.lo !== l0) st = 1'b0;
      n++;
      if (n == 2) begin bus.src_a = 32'hDEADBEEF; bus.src_b = 32'hDEADBEEF; bus.md_op = 3'd5; bus.start = 1'b1; end
      if (n == 3) bus.start = 1'b0;
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    model_op(3'd0, 32'd3, 32'd4, m_hi, m_lo, c);
    checks++; if (n !== 5) begin fails++; $display("FAIL iso_busy_len: got %0d expected 5", n); end
    checks++; if (!st) begin fails++; $display("FAIL iso_mtlo_dropped: hi/lo changed during busy, expected held"); end
    checks++; if (bus.lo !== 32'hC || bus.hi !== 32'd0) begin fails++; $display("FAIL iso_result: got hi=%h lo=%h expected hi=00000000 lo=0000000c", bus.hi, bus.lo); end
  endtask

  task automatic test_reset_mid_op();
    int n, c; bit st;
    run_op(3'd4, 32'hAAAA, 32'h0, n, st);
    run_op(3'd5, 32'hBBBB, 32'h0, n, st);
    @(negedge clk);
    bus.start = 1'b1; bus.md_op = 3'd2; bus.src_a = 32'd100; bus.src_b = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL midreset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin fails++; $display("FAIL midreset_hilo: got hi=%h lo=%h expected 0/0", bus.hi, bus.lo); end
    run_op(3'd0, 32'd2, 32'd3, n, st);
    model_op(3'd0, 32'd2, 32'd3, m_hi, m_lo, c);
    checks++; if (n !== 5) begin fails++; $display("FAIL midreset_mult_len: got %0d expected 5", n); end
    checks++; if (bus.lo !== 32'd6 || bus.hi !== 32'd0) begin fails++; $display("FAIL midreset_mult: got hi=%h lo=%h expected hi=00000000 lo=00000006", bus.hi, bus.lo); end
  endtask

  task automatic test_back_to_back();
    int n, c; bit st;
    run_op(3'd1, 32'h12345, 32'h10, n, st);
    model_op(3'd1, 32'h12345, 32'h10, m_hi, m_lo, c);
    run_op(3'd3, m_lo, 32'h10, n, st);
    model_op(3'd3, m_lo, 32'h10, m_hi, m_lo, c);
    checks++; if (n !== 10) begin fails++; $display("FAIL b2b_busy_len: got %0d expected 10", n); end
    checks++; if (bus.lo !== 32'h12345 || bus.hi !== 32'd0) begin fails++; $display("FAIL b2b_result: got hi=%h lo=%h expected hi=00000000 lo=00012345", bus.hi, bus.lo); end
  endtask

  task automatic test_random();
    int n, c; bit st;
    logic [2:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = $urandom_range(1, 9);
        2: b = 32'hFFFFFFFF;
        default: b = $urandom;
      endcase
      run_op(op, a, b, n, st);
      model_op(op, a, b, m_hi, m_lo, c);
      checks++; if (n !== c) begin fails++; $display("FAIL rand_busy_len[%0d] op=%0d: got %0d expected %0d", i, op, n, c); end
      checks++; if (!st) begin fails++; $display("FAIL rand_hold[%0d] op=%0d: hi/lo changed during busy, expected held", i, op); end
      checks++; if (bus.hi !== m_hi || bus.lo !== m_lo) begin
        fails++;
        $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got hi=%h lo=%h expected hi=%h lo=%h", i, op, a, b, bus.hi, bus.lo, m_hi, m_lo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo_divzero();
    test_isolation();
    test_reset_mid_op();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
